// File: rtl/spi_mmio_master.sv
// spi_mmio_master: memory-mapped SPI master (mode 0, MSB first).
// CPU writes DATA, issues SEND through CTRL, polls BUSY, then reads the captured miso byte from DATA.
module spi_mmio_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NBITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        mosi,
  input  logic        miso,
  output logic        ss,
  output logic        sck
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LEAD,
    S_TRAIL,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [BW-1:0]      r_bit;
  logic [NBITS-1:0]   r_tx_hold;
  logic [NBITS-1:0]   r_shift;
  logic [NBITS-1:0]   r_rx_sh;
  logic [NBITS-1:0]   r_rx_data;
  logic               r_mosi;
  logic               r_busy;
  logic               r_rdy;

  logic w_wr_data;
  logic w_wr_ctrl;
  logic w_rd_data;
  logic w_send;
  logic w_last;
  logic w_done;
  logic w_unused_wd;

  assign w_wr_data   = sel && we && (addr == 3'd0);
  assign w_wr_ctrl   = sel && we && (addr == 3'd4);
  assign w_rd_data   = sel && !we && (addr == 3'd0);
  assign w_send      = w_wr_ctrl && wd[2] && !r_busy;
  assign w_last      = (r_cnt == C_LAST);
  assign w_done      = (r_state == S_HOLD) && w_last;
  assign w_unused_wd = ^wd;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; BUSY is raised one clk before SETUP, which supplies the extra clk of SEND-to-idle latency
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_busy) w_next = S_SETUP;
      S_SETUP: if (w_last) w_next = S_LEAD;
      S_LEAD:  if (w_last) w_next = S_TRAIL;
      S_TRAIL: if (w_last) w_next = (r_bit == B_LAST) ? S_HOLD : S_LEAD;
      S_HOLD:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SPI pin outputs decoded from state
  always_comb begin
    ss   = 1'b1;
    sck  = 1'b0;
    mosi = r_mosi;
    case (r_state)
      S_SETUP, S_TRAIL, S_HOLD: ss = 1'b0;
      S_LEAD: begin
        ss  = 1'b0;
        sck = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-state clk divider and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      if (r_state == S_IDLE || w_last) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE)                  r_bit <= '0;
      else if (r_state == S_TRAIL && w_last) r_bit <= r_bit + 1'b1;
    end
  end

  // Bus registers, shift registers and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_hold <= '0;
      r_shift   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      if (w_wr_data) r_tx_hold <= wd[NBITS-1:0];
      if (w_send) begin
        r_shift <= r_tx_hold;
        r_busy  <= 1'b1;
      end
      if (r_state == S_IDLE && r_busy) r_mosi <= r_shift[NBITS-1];
      if (r_state == S_LEAD && w_last) begin
        r_rx_sh <= {r_rx_sh[NBITS-2:0], miso};
        if (r_bit != B_LAST) begin
          r_shift <= r_shift << 1;
          r_mosi  <= r_shift[NBITS-2];
        end
      end
      if (w_done) begin
        r_rx_data <= r_rx_sh;
        r_busy    <= 1'b0;
        r_rdy     <= 1'b1;
      end else if (w_rd_data) begin
        r_rdy <= 1'b0;
      end
    end
  end

  // Combinational read mux
  always_comb begin
    rd = '0;
    case (addr)
      3'd0:    rd = 32'(r_rx_data);
      3'd4:    rd = {29'b0, 1'b0, r_busy, r_rdy};
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_mmio_master.sv
// tb_spi_mmio_master: directed + random checks of spi_mmio_master against a behavioural SPI slave model.
module tb_spi_mmio_master;

  localparam int LAT = (2 * 8 + 2) * 2 + 1;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        sel  = 1'b0;
  logic        we   = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wd   = '0;
  logic [31:0] rd;
  logic        mosi;
  logic        miso;
  logic        ss;
  logic        sck;

  int errors = 0;
  int checks = 0;

  spi_mmio_master #(.CLK_DIV(2), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .mosi(mosi), .miso(miso), .ss(ss), .sck(sck)
  );

  always #5 clk = ~clk;

  // Behavioural mode-0 slave: loads its reply on ss fall, samples mosi on sck rise, advances miso on sck fall
  logic [7:0] s_tx = '0;
  logic [7:0] s_sh = '0;
  logic [7:0] s_in = '0;
  int         s_bits = 0;
  int         sck_rises = 0;
  logic       ss_p = 1'b1;
  logic       sck_p = 1'b0;
  logic [7:0] rx_q[$];

  assign miso = s_sh[7];

  always @(ss or sck) begin
    if (ss_p && !ss) begin
      s_sh   = s_tx;
      s_bits = 0;
    end else if (!sck_p && sck) begin
      sck_rises++;
      if (!ss) begin
        s_in = {s_in[6:0], mosi};
        s_bits++;
        if (s_bits == 8) rx_q.push_back(s_in);
      end
    end else if (sck_p && !sck && !ss) begin
      s_sh = s_sh << 1;
    end
    ss_p  = ss;
    sck_p = sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = rd;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    sel = 1'b1; we = 1'b0; addr = 3'd4;
    #1;
    while (rd[1] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    sel = 1'b0;
    chk("busy_bound", 32'(n < 500), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] reply);
    int n;
    logic [31:0] v;
    bus_write(3'd0, {24'h0, b});
    s_tx = reply;
    bus_write(3'd4, 32'h4);
    wait_idle(n);
    chk("latency", n, LAT);
    chk("wire_byte", {24'h0, rx_q[$]}, {24'h0, b});
    bus_read(3'd0, v);
    chk("rx_byte", v, {24'h0, reply});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [31:0] words[2];
    logic [31:0] w;
    int n, qb, base, t;

    // Reset state
    #12;
    chk("rst_ss", ss, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    sel = 1'b1; addr = 3'd4; #1;
    chk("rst_status", rd, 0);
    addr = 3'd0; #1;
    chk("rst_data", rd, 0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single byte A5 out, 3C back
    qb = rx_q.size();
    bus_write(3'd0, 32'hA5);
    s_tx = 8'h3C;
    bus_write(3'd4, 32'h4);
    wait_idle(n);
    chk("single_latency", n, LAT);
    chk("single_count", rx_q.size() - qb, 1);
    chk("single_wire", {24'h0, rx_q[$]}, 32'hA5);
    bus_read(3'd4, v); chk("single_status_rdy", v, 32'h1);
    bus_read(3'd0, v); chk("single_data", v, 32'h3C);
    bus_read(3'd4, v); chk("single_status_clr", v, 32'h0);

    // Second SEND while busy is ignored
    qb = rx_q.size();
    base = sck_rises;
    bus_write(3'd0, 32'h5A);
    s_tx = 8'h81;
    bus_write(3'd4, 32'h4);
    repeat (3) begin @(posedge clk); #1; end
    bus_write(3'd4, 32'h4);
    wait_idle(n);
    repeat (40) begin @(posedge clk); #1; end
    chk("busy_send_rises", sck_rises - base, 8);
    chk("busy_send_count", rx_q.size() - qb, 1);
    chk("busy_send_wire", {24'h0, rx_q[$]}, 32'h5A);
    bus_read(3'd4, v); chk("busy_send_status", v, 32'h1);
    bus_read(3'd0, v); chk("busy_send_data", v, 32'h81);

    // DATA write during a transfer only affects the next SEND
    bus_write(3'd0, 32'hF0);
    bus_write(3'd4, 32'h4);
    repeat (6) begin @(posedge clk); #1; end
    bus_write(3'd0, 32'h11);
    wait_idle(n);
    chk("midwrite_wire0", {24'h0, rx_q[$]}, 32'hF0);
    bus_write(3'd4, 32'h4);
    wait_idle(n);
    chk("midwrite_wire1", {24'h0, rx_q[$]}, 32'h11);
    bus_read(3'd0, v);

    // Address decode and sel qualification
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd4, v); chk("dec_status", v, 32'h0);
    bus_read(3'd2, v); chk("dec_rd2", v, 32'h0);
    bus_read(3'd6, v); chk("dec_rd6", v, 32'h0);
    sel = 1'b0; we = 1'b1; addr = 3'd4; wd = 32'h4;
    @(posedge clk); #1;
    addr = 3'd0; wd = 32'h77;
    @(posedge clk); #1;
    we = 1'b0;
    bus_read(3'd4, v); chk("nosel_status", v, 32'h0);
    qb = rx_q.size();
    bus_write(3'd4, 32'h4);
    wait_idle(n);
    chk("dec_count", rx_q.size() - qb, 1);
    chk("dec_hold", {24'h0, rx_q[$]}, 32'h11);
    bus_read(3'd0, v);

    // Word stream, LSB byte first
    words[0] = 32'hdeadc0de;
    words[1] = 32'hdeadbeef;
    qb = rx_q.size();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        w = words[i];
        send_byte(w[8*k +: 8], 8'($urandom));
      end
    chk("stream_bytes", rx_q.size() - qb, 8);
    for (int i = 0; i < 2; i++) begin
      w = {rx_q[qb+4*i+3], rx_q[qb+4*i+2], rx_q[qb+4*i+1], rx_q[qb+4*i]};
      chk("stream_word", w, words[i]);
    end

    // Random bytes in both directions
    repeat (6) send_byte(8'($urandom), 8'($urandom));

    // Asynchronous reset during bit 3
    qb = rx_q.size();
    base = sck_rises;
    bus_write(3'd0, $urandom);
    bus_write(3'd4, 32'h4);
    t = 0;
    while (sck_rises < base + 4 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bit3_reached", 32'(t < 200), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ss", ss, 1);
    chk("midrst_sck", sck, 0);
    sel = 1'b1; we = 1'b0; addr = 3'd4; #1;
    chk("midrst_status", rd, 0);
    addr = 3'd0; #1;
    chk("midrst_data", rd, 0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (50) begin @(posedge clk); #1; end
    chk("midrst_no_byte", rx_q.size() - qb, 0);
    chk("midrst_no_sck", sck_rises - base, 4);
    bus_read(3'd4, v); chk("midrst_status_after", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
